// File: rtl/bus_timer_irq_if.sv
// CPU-side bus bundle for the timer: address/data/strobes in, read data and chip select out.
interface bus_timer_irq_if;
  logic [15:0] address;
  logic [7:0]  data_i;
  logic        write;
  logic        ready;
  logic [7:0]  data_o;
  logic        cs;

  modport master (output address, data_i, write, ready, input data_o, cs);
  modport slave  (input address, data_i, write, ready, output data_o, cs);
endinterface

// File: rtl/bus_timer_irq.sv
// Memory-mapped 16-bit interval timer with a soft I/O port, driving the CPU irq/nmi lines.
module bus_timer_irq #(
  parameter logic [15:0] BASE_ADDR = 16'hbff8,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  bus_timer_irq_if.slave   bus,
  output logic             irq,
  output logic             nmi
);

  localparam logic [7:0] PS_MAX = 8'(PRESCALE - 1);

  logic [7:0]  tlo, thi, port_reg, presc;
  logic [15:0] cnt;
  logic        en, cont, ie, nsel, tf;
  logic [2:0]  off;
  logic        commit, wr_tlo, wr_thi, wr_ctrl, wr_stat, wr_port;
  logic        tick, underflow;

  assign bus.cs  = (bus.address[15:3] == BASE_ADDR[15:3]);
  assign off     = bus.address[2:0];
  assign commit  = bus.cs & bus.write & bus.ready;
  assign wr_tlo  = commit && (off == 3'd0);
  assign wr_thi  = commit && (off == 3'd1);
  assign wr_ctrl = commit && (off == 3'd2);
  assign wr_stat = commit && (off == 3'd3);
  assign wr_port = commit && (off == 3'd6);

  // A THI load on a tick edge swallows that tick, including any underflow.
  assign tick      = en && (presc == PS_MAX);
  assign underflow = tick && (cnt == '0) && !wr_thi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (wr_thi || !en || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (wr_thi) begin
      cnt <= {bus.data_i, tlo};
    end else if (tick) begin
      if (cnt != '0) cnt <= cnt - 16'd1;
      else if (cont) cnt <= {thi, tlo};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tlo      <= '0;
      thi      <= '0;
      port_reg <= '0;
      en       <= 1'b0;
      cont     <= 1'b0;
      ie       <= 1'b0;
      nsel     <= 1'b0;
    end else begin
      if (wr_tlo)  tlo      <= bus.data_i;
      if (wr_port) port_reg <= bus.data_i;
      if (wr_thi) begin
        thi <= bus.data_i;
        en  <= 1'b1;
      end else if (wr_ctrl) begin
        en   <= bus.data_i[0];
        cont <= bus.data_i[1];
        ie   <= bus.data_i[2];
        nsel <= bus.data_i[3];
      end else if (underflow && !cont) begin
        en <= 1'b0;
      end
    end
  end

  // Setting the flag takes priority over a software clear on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tf <= 1'b0;
    end else if (underflow) begin
      tf <= 1'b1;
    end else if (wr_stat && bus.data_i[0]) begin
      tf <= 1'b0;
    end
  end

  always_comb begin
    bus.data_o = '0;
    if (bus.cs) begin
      unique case (off)
        3'd0:    bus.data_o = tlo;
        3'd1:    bus.data_o = thi;
        3'd2:    bus.data_o = {4'b0000, nsel, ie, cont, en};
        3'd3:    bus.data_o = {7'b0000000, tf};
        3'd4:    bus.data_o = cnt[7:0];
        3'd5:    bus.data_o = cnt[15:8];
        3'd6:    bus.data_o = port_reg;
        default: bus.data_o = '0;
      endcase
    end
  end

  assign irq = port_reg[0] | (tf & ie & ~nsel);
  assign nmi = port_reg[1] | (tf & ie & nsel);

endmodule

// File: doc/bus_timer_irq.md
Name: bus_timer_irq

Overview:
- Memory-mapped interval timer and interrupt source on the cpu6502 bus.
- Decodes an 8-byte window, holds the software I/O port, and drives the CPU irq/nmi inputs directly. It is the upstream producer of those interrupt lines.
- Sits beside main memory on the shared address/data bus. The system read mux selects data_o whenever cs is high.

Parameters:
- BASE_ADDR, 16'hbff8, base of the 8-byte register window; must be 8-aligned.
- PRESCALE, 1, clk cycles per counter decrement (1..256).

Ports:
- clk  in  1  CPU clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  16  CPU address bus.
- data_i  in  8  CPU write data (cpu data_o).
- write  in  1  CPU write strobe, active high.
- ready  in  1  CPU ready; bus writes commit only when high.
- data_o  out  8  read data; valid when cs is high, combinational.
- cs  out  1  high when address[15:3] == BASE_ADDR[15:3].
- irq  out  1  level interrupt request to the CPU, active high.
- nmi  out  1  NMI request level to the CPU, active high; the CPU edge-detects it.

Behaviour:
- Register offsets are address[2:0].
  - 0 TLO: reload latch, low byte.
  - 1 THI: reload latch, high byte. A write also loads the counter and starts timing.
  - 2 CTRL: bit0 EN, bit1 CONT (auto-reload), bit2 IE, bit3 NSEL (route the timer flag to nmi instead of irq).
  - 3 STAT: bit0 TF. Writing 1 to bit0 clears TF; a read has no side effect.
  - 4 CNTL: counter low byte, read-only.
  - 5 CNTH: counter high byte, read-only.
  - 6 PORT: bit0 soft irq, bit1 soft nmi; bits 7:2 are plain storage.
  - 7: reads 8'h00; writes are ignored.
- Write commit: a register updates on the posedge where cs & write & ready are all high. With ready low, nothing changes.
- Reads: data_o = mux(address[2:0]); unused CTRL/STAT bits read 0. When cs is low, data_o = 8'h00.
- Reset (async, reset_n low): all registers 0, counter 0, prescaler 0, TF 0. irq = 0, nmi = 0, data_o = 0. A reset mid-count aborts the count immediately.
- Prescaler:
  - Counts 0..PRESCALE-1 while EN is set and wraps; a tick is issued on the wrap.
  - With PRESCALE = 1, every cycle is a tick.
  - A THI write or EN = 0 clears the prescaler to 0.
- THI write:
  - counter <= {data_i, TLO}, prescaler <= 0, EN <= 1.
  - The CTRL value of CONT/IE/NSEL is kept.
- Counter on each tick with EN = 1:
  - counter != 0: counter <= counter - 1.
  - counter == 0 (underflow): TF <= 1. If CONT, counter <= {THI, TLO}; otherwise EN <= 0 and the counter stays 0.
- Latency: after a load with value V and PRESCALE = 1, TF rises at the (V+1)th posedge after the load edge. V = 0 gives TF on the next edge. The period is (V+1)*PRESCALE cycles.
- Simultaneous events on the same edge:
  - TF set vs. a W1C clear: set wins, TF stays 1.
  - THI write vs. tick: the load wins and that tick is discarded.
  - CTRL write vs. a THI auto-start: only one can occur per edge (different offsets).
  - CTRL write with EN = 0 during a count freezes the counter at its current value. Writing EN = 1 resumes from that value.
- Outputs are registered from state, with no combinational path from the bus:
  - irq = PORT[0] | (TF & IE & ~NSEL).
  - nmi = PORT[1] | (TF & IE & NSEL).
- TF sets regardless of IE; IE only gates the outputs.

Test Plan:
- Reset: hold reset_n = 0, then release → irq = 0, nmi = 0. Reads of offsets 0..7 at 16'hbff8..bfff return 00. Address 16'hbff0 gives cs = 0.
- One-shot: PRESCALE = 1; write TLO = 03, CTRL = 04, THI = 00 → CNTL reads 03,02,01,00. TF and irq rise on the 4th edge after the THI write. EN reads 0 and the counter holds 0. Writing STAT = 01 drops irq next edge.
- Continuous + NSEL: write TLO = 01, CTRL = 0E, THI = 00 → nmi rises 2 cycles after the load. The counter reloads to 0001. After a W1C, TF sets again 2 cycles later. irq stays 0 throughout.
- Ready gating: a THI write with ready = 0 for 3 cycles → no load until the first ready = 1 edge. The counter is unchanged before that edge.
- Simultaneous: issue a W1C to STAT on the exact underflow edge → TF remains 1. Issue a THI write on a tick edge → the counter equals the new load value, not load-1.
- Soft port and prescaler:
  - Write PORT = 03 → irq = 1 and nmi = 1 next edge. Write PORT = 00 → both clear.
  - With PRESCALE = 4 and a load of 0001 → TF at cycle 8.
  - Pulse reset_n low mid-count → TF = 0 and the counter = 0 immediately.
